sample_fifo_ctrl: RTL and testbench
===================================

SAMPLE_FIFO_CTRL -- requirements
Module: sample_fifo_ctrl

Interface
REQ-001 SHALL have parameters: FIFO_WIDTH, default 16, data width. CNT_W, default 10, item-count width. PASS_W, default 4, pass-count width.
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 i_start in 1 job start. i_num_items in CNT_W items per job. i_num_passes in PASS_W replay passes.
REQ-005 o_busy out 1 job in progress. o_done out 1 one-cycle pulse at job end.
REQ-006 s_valid in 1, s_data in FIFO_WIDTH, s_ready out 1: upstream fill stream.
REQ-007 m_valid out 1, m_data out FIFO_WIDTH, m_ready in 1, m_last out 1, m_pass out PASS_W: downstream replay stream.
REQ-008 o_fifo_flush, o_fifo_read_rst, o_fifo_mark_read_rst, o_fifo_push, o_fifo_pop out 1, o_fifo_rear out FIFO_WIDTH: FIFO control.
REQ-009 i_fifo_full, i_fifo_empty, i_fifo_vld in 1, i_fifo_front in FIFO_WIDTH: FIFO status; i_fifo_vld/front valid exactly 1 cycle after o_fifo_pop.

Function
REQ-010 SHALL implement FSM IDLE, MARK, FILL, DRAIN, REWIND, FLUSH, DONE.
REQ-011 IDLE: i_start with i_num_items!=0 and i_num_passes!=0 latches both and goes to MARK; i_start with either zero goes directly to DONE.
REQ-012 MARK: o_fifo_mark_read_rst=1 for exactly one cycle, then FILL.
REQ-013 FILL: s_ready = !i_fifo_full; o_fifo_push = s_valid & s_ready; o_fifo_rear = s_data (combinational). After the i_num_items-th push, go to DRAIN with pass=0.
REQ-014 DRAIN: 2-entry output skid buffer. o_fifo_pop=1 when (buffered + in-flight pops) < 2, !i_fifo_empty, and pops issued this pass < i_num_items. Each i_fifo_vld writes i_fifo_front into the buffer. Sustains 1 item/cycle while m_ready=1.
REQ-015 m_valid = buffer non-empty; m_data = buffer head. m_data, m_pass, m_last SHALL be held stable while m_valid & !m_ready.
REQ-016 m_last=1 on the i_num_items-th beat of each pass; m_pass = current pass index.
REQ-017 After the last beat of a pass is accepted: if pass < i_num_passes-1, go to REWIND; else go to FLUSH.
REQ-018 REWIND: o_fifo_read_rst=1 for one cycle; increment pass; return to DRAIN. No pop in the same cycle.
REQ-019 FLUSH: o_fifo_flush=1 for one cycle, then DONE. DONE: o_done=1 for one cycle, then IDLE.
REQ-020 o_busy=1 in every state except IDLE. i_start is ignored while o_busy=1.
REQ-021 FIFO strobes (push, pop, flush, read_rst, mark_read_rst) are mutually exclusive in any cycle.
REQ-022 Counters wrap-free: item counter saturates at i_num_items; pass counter is PASS_W bits; i_num_items up to 2^CNT_W-1.

Reset
REQ-023 rst: FSM=IDLE, counters=0, skid buffer empty. Outputs: m_valid=0, s_ready=0, o_busy=0, o_done=0, m_last=0, m_pass=0, m_data=0, all FIFO strobes=0.
REQ-024 rst mid-job abandons the job with no flush pulse; the FIFO is reset by its own reset.

Configuration
REQ-025 Macro SAMPLE_FIFO_CTRL_ABORT_EN.
- Defined: adds input i_abort (1 bit). i_abort in any non-IDLE state empties the skid buffer, drops m_valid next cycle, discards late i_fifo_vld, and goes to FLUSH then DONE.
- Undefined: no i_abort port; a job runs to completion.

Verification
REQ-026 items=4, passes=3, s_valid=1, m_ready=1 -> 12 beats; m_pass 0,0,0,0,1,...,2; m_last on beats 4/8/12; exactly 1 mark, 2 read_rst, 1 flush, then o_done.
REQ-027 items=5, passes=1, i_fifo_full forced during push 3 for 4 cycles -> s_ready=0 during those cycles; no push is lost; data order is preserved.
REQ-028 m_ready toggling 1/0 each cycle with items=8 -> m_data stable while stalled; never more than 2 pops outstanding; all 8 values correct.
REQ-029 i_start with items=0 -> o_done 1 cycle later; no FIFO strobes issued.
REQ-030 rst asserted in DRAIN of pass 1 -> next cycle all outputs match REQ-023; a new job then runs correctly.
REQ-031 With SAMPLE_FIFO_CTRL_ABORT_EN: i_abort during pass 0 beat 2 -> m_valid=0 next cycle, flush pulse, o_done pulse, return to IDLE.

Source files
------------

// File: rtl/sample_fifo_ctrl.sv
// Fill-once / replay-N controller for an external FIFO with a mark/rewind read pointer.
// Optional abort input is enabled by defining SAMPLE_FIFO_CTRL_ABORT_EN.
module sample_fifo_ctrl #(
  parameter int unsigned FIFO_WIDTH = 16,
  parameter int unsigned CNT_W      = 10,
  parameter int unsigned PASS_W     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [CNT_W-1:0]      i_num_items,
  input  logic [PASS_W-1:0]     i_num_passes,
`ifdef SAMPLE_FIFO_CTRL_ABORT_EN
  input  logic                  i_abort,
`endif
  output logic                  o_busy,
  output logic                  o_done,
  input  logic                  s_valid,
  input  logic [FIFO_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  m_valid,
  output logic [FIFO_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic [PASS_W-1:0]     m_pass,
  output logic                  o_fifo_flush,
  output logic                  o_fifo_read_rst,
  output logic                  o_fifo_mark_read_rst,
  output logic                  o_fifo_push,
  output logic                  o_fifo_pop,
  output logic [FIFO_WIDTH-1:0] o_fifo_rear,
  input  logic                  i_fifo_full,
  input  logic                  i_fifo_empty,
  input  logic                  i_fifo_vld,
  input  logic [FIFO_WIDTH-1:0] i_fifo_front
);

  typedef enum logic [2:0] {
    S_IDLE, S_MARK, S_FILL, S_DRAIN, S_REWIND, S_FLUSH, S_DONE
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      items_q;
  logic [PASS_W-1:0]     passes_q;
  logic [CNT_W-1:0]      push_cnt;
  logic [CNT_W-1:0]      pop_cnt;
  logic [CNT_W-1:0]      beat_cnt;
  logic [PASS_W-1:0]     pass_q;
  logic                  inflight;
  logic [FIFO_WIDTH-1:0] buf0;
  logic [FIFO_WIDTH-1:0] buf1;
  logic [1:0]            buf_cnt;

  logic       abort_c;
  logic       in_drain;
  logic       deq;
  logic       enq;
  logic       last_beat;
  logic [2:0] occ_next;

`ifdef SAMPLE_FIFO_CTRL_ABORT_EN
  assign abort_c = i_abort && (state inside {S_MARK, S_FILL, S_DRAIN, S_REWIND});
`else
  assign abort_c = 1'b0;
`endif

  assign in_drain  = (state == S_DRAIN);
  assign m_valid   = (buf_cnt != 2'd0);
  assign m_data    = buf0;
  assign m_pass    = pass_q;
  assign m_last    = m_valid && (beat_cnt == items_q - CNT_W'(1));
  assign deq       = in_drain && m_valid && m_ready;
  assign enq       = in_drain && i_fifo_vld;
  assign last_beat = deq && (beat_cnt == items_q - CNT_W'(1));

  // Skid occupancy after this edge, counting the read whose data arrives now
  assign occ_next  = 3'(buf_cnt) - 3'(deq) + 3'(inflight);

  assign o_fifo_pop = in_drain && !abort_c && (occ_next < 3'd2) &&
                      !i_fifo_empty && (pop_cnt < items_q);

  assign s_ready              = (state == S_FILL) && !i_fifo_full && !abort_c;
  assign o_fifo_push          = s_valid && s_ready;
  assign o_fifo_rear          = s_data;
  assign o_fifo_mark_read_rst = (state == S_MARK);
  assign o_fifo_read_rst      = (state == S_REWIND);
  assign o_fifo_flush         = (state == S_FLUSH);
  assign o_done               = (state == S_DONE);
  assign o_busy               = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      items_q  <= '0;
      passes_q <= '0;
      push_cnt <= '0;
      pop_cnt  <= '0;
      beat_cnt <= '0;
      pass_q   <= '0;
      inflight <= 1'b0;
      buf0     <= '0;
      buf1     <= '0;
      buf_cnt  <= '0;
    end else begin
      inflight <= o_fifo_pop;

      // Two-entry output skid buffer; head is always buf0
      if (abort_c) begin
        buf_cnt <= '0;
      end else if (enq && deq) begin
        if (buf_cnt == 2'd2) begin
          buf0 <= buf1;
          buf1 <= i_fifo_front;
        end else begin
          buf0 <= i_fifo_front;
        end
      end else if (deq) begin
        buf0    <= buf1;
        buf_cnt <= buf_cnt - 2'd1;
      end else if (enq) begin
        if (buf_cnt == 2'd0) buf0 <= i_fifo_front;
        else                 buf1 <= i_fifo_front;
        buf_cnt <= buf_cnt + 2'd1;
      end

      case (state)
        S_IDLE: begin
          if (i_start) begin
            if ((i_num_items != '0) && (i_num_passes != '0)) begin
              items_q  <= i_num_items;
              passes_q <= i_num_passes;
              push_cnt <= '0;
              pass_q   <= '0;
              state    <= S_MARK;
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_MARK: state <= S_FILL;
        S_FILL: begin
          if (o_fifo_push) begin
            push_cnt <= push_cnt + CNT_W'(1);
            if (push_cnt == items_q - CNT_W'(1)) begin
              pop_cnt  <= '0;
              beat_cnt <= '0;
              pass_q   <= '0;
              state    <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (o_fifo_pop) pop_cnt <= pop_cnt + CNT_W'(1);
          if (deq)        beat_cnt <= beat_cnt + CNT_W'(1);
          if (last_beat) begin
            if (pass_q == passes_q - PASS_W'(1)) state <= S_FLUSH;
            else                                 state <= S_REWIND;
          end
        end
        S_REWIND: begin
          pass_q   <= pass_q + PASS_W'(1);
          pop_cnt  <= '0;
          beat_cnt <= '0;
          state    <= S_DRAIN;
        end
        S_FLUSH: state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      if (abort_c) state <= S_FLUSH;
    end
  end

endmodule

// File: tb/tb_sample_fifo_ctrl.sv
// Bench for sample_fifo_ctrl: FIFO model with mark/rewind, replay scoreboard, directed and random jobs.
module tb_sample_fifo_ctrl;
  localparam int unsigned FW = 16;
  localparam int unsigned CW = 10;
  localparam int unsigned PW = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, i_start, o_busy, o_done;
  logic [CW-1:0] i_num_items;
  logic [PW-1:0] i_num_passes;
  logic          s_valid, s_ready, m_valid, m_ready, m_last;
  logic [FW-1:0] s_data, m_data, o_fifo_rear, i_fifo_front;
  logic [PW-1:0] m_pass;
  logic          o_fifo_flush, o_fifo_read_rst, o_fifo_mark_read_rst, o_fifo_push, o_fifo_pop;
  logic          i_fifo_full, i_fifo_empty, i_fifo_vld;
`ifdef SAMPLE_FIFO_CTRL_ABORT_EN
  logic          i_abort;
  logic          abort_req;
`endif

  sample_fifo_ctrl #(.FIFO_WIDTH(FW), .CNT_W(CW), .PASS_W(PW)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_num_items(i_num_items),
    .i_num_passes(i_num_passes),
`ifdef SAMPLE_FIFO_CTRL_ABORT_EN
    .i_abort(i_abort),
`endif
    .o_busy(o_busy), .o_done(o_done),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready), .m_last(m_last), .m_pass(m_pass),
    .o_fifo_flush(o_fifo_flush), .o_fifo_read_rst(o_fifo_read_rst),
    .o_fifo_mark_read_rst(o_fifo_mark_read_rst), .o_fifo_push(o_fifo_push),
    .o_fifo_pop(o_fifo_pop), .o_fifo_rear(o_fifo_rear),
    .i_fifo_full(i_fifo_full), .i_fifo_empty(i_fifo_empty), .i_fifo_vld(i_fifo_vld),
    .i_fifo_front(i_fifo_front)
  );

  // FIFO model: pointers are absolute counts, mark holds the replay start
  int            wr, rd, mk;
  logic [FW-1:0] mem [DEPTH];
  logic          force_full;
  assign i_fifo_empty = (rd == wr);
  assign i_fifo_full  = force_full || ((wr - mk) >= DEPTH);

  always @(posedge clk) begin
    i_fifo_vld <= 1'b0;
    if (rst || o_fifo_flush) begin
      wr <= 0; rd <= 0; mk <= 0;
    end else begin
      if (o_fifo_push) begin
        mem[wr[3:0]] <= o_fifo_rear;
        wr <= wr + 1;
      end
      if (o_fifo_pop) begin
        i_fifo_front <= mem[rd[3:0]];
        i_fifo_vld   <= 1'b1;
        rd <= rd + 1;
      end
      if (o_fifo_mark_read_rst) mk <= rd;
      if (o_fifo_read_rst)      rd <= mk;
    end
  end

  int n_tests, n_fail;
  int n_push, n_pop, n_beat, n_mark, n_rrst, n_flush, n_done, n_strb;
  int j_items, j_passes;
  logic [FW-1:0] pushed [$];
  int sv_mode, mr_mode, force_left;
  bit ff_arm, rst_req, start_req, prev_stall;
  int start_items, start_passes;
  logic [FW-1:0] prev_data;
  logic [PW-1:0] prev_pass;
  logic          prev_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Per-cycle observation of handshakes and strobes, compared against the replay model
  task automatic monitor();
    int idx;
    logic [FW-1:0] exp_d;
    if (rst) begin
      prev_stall = 1'b0;
      return;
    end
    check("strobe_excl", 32'($countones({o_fifo_push, o_fifo_pop, o_fifo_flush,
                                          o_fifo_read_rst, o_fifo_mark_read_rst}) <= 1), 32'd1);
    if (o_fifo_pop) check("pop_when_empty", 32'(i_fifo_empty), 32'd0);
    if (force_full) check("s_ready_while_full", 32'(s_ready), 32'd0);
    if (prev_stall) begin
      check("stall_valid", 32'(m_valid), 32'd1);
      check("stall_data", 32'(m_data), 32'(prev_data));
      check("stall_pass", 32'(m_pass), 32'(prev_pass));
      check("stall_last", 32'(m_last), 32'(prev_last));
    end
    if (o_fifo_push) begin
      pushed.push_back(s_data);
      n_push++;
    end
    if (o_fifo_pop) n_pop++;
    if (m_valid && m_ready) begin
      idx   = n_beat % j_items;
      exp_d = (idx < pushed.size()) ? pushed[idx] : 'x;
      check("beat_in_range", 32'(n_beat < j_items * j_passes), 32'd1);
      check("beat_data", 32'(m_data), 32'(exp_d));
      check("beat_pass", 32'(m_pass), 32'(n_beat / j_items));
      check("beat_last", 32'(m_last), 32'(idx == j_items - 1));
      n_beat++;
    end
    check("outstanding_le2", 32'((n_pop - n_beat) <= 2), 32'd1);
    if (o_fifo_mark_read_rst) n_mark++;
    if (o_fifo_read_rst) n_rrst++;
    if (o_fifo_flush) n_flush++;
    if (o_done) n_done++;
    n_strb += 32'($countones({o_fifo_push, o_fifo_pop, o_fifo_flush,
                              o_fifo_read_rst, o_fifo_mark_read_rst}));
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
    prev_pass  = m_pass;
    prev_last  = m_last;
  endtask

  task automatic tick();
    @(negedge clk);
    rst          = rst_req;
    i_start      = start_req;
    i_num_items  = CW'(start_items);
    i_num_passes = PW'(start_passes);
    s_valid      = (sv_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
    s_data       = FW'($urandom);
    case (mr_mode)
      1:       m_ready = 1'b1;
      2:       m_ready = ~m_ready;
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
`ifdef SAMPLE_FIFO_CTRL_ABORT_EN
    i_abort = abort_req;
`endif
    if (ff_arm && n_push == 2) begin
      force_left = 4;
      ff_arm     = 1'b0;
    end
    force_full = (force_left > 0);
    #1;
    monitor();
    if (force_left > 0) force_left--;
  endtask

  task automatic new_job(input int items, input int passes);
    n_push = 0; n_pop = 0; n_beat = 0; n_mark = 0; n_rrst = 0;
    n_flush = 0; n_done = 0; n_strb = 0;
    pushed.delete();
    prev_stall   = 1'b0;
    j_items      = items;
    j_passes     = passes;
    start_items  = items;
    start_passes = passes;
    start_req    = 1'b1;
    tick();
    start_req    = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int c = 0;
    while (n_done == 0 && c < budget) begin
      tick();
      c++;
    end
    check("done_timeout", 32'(n_done != 0), 32'd1);
    tick();
    check("done_one_cycle", 32'(o_done), 32'd0);
    check("idle_after_done", 32'(o_busy), 32'd0);
  endtask

  task automatic end_checks();
    check("job_beats", 32'(n_beat), 32'(j_items * j_passes));
    check("job_pushes", 32'(n_push), 32'(j_items));
    check("job_marks", 32'(n_mark), 32'd1);
    check("job_rewinds", 32'(n_rrst), 32'(j_passes - 1));
    check("job_flushes", 32'(n_flush), 32'd1);
    check("job_done_pulses", 32'(n_done), 32'd1);
  endtask

  task automatic reset_outs();
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    check("rst_m_pass", 32'(m_pass), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_push", 32'(o_fifo_push), 32'd0);
    check("rst_pop", 32'(o_fifo_pop), 32'd0);
    check("rst_flush", 32'(o_fifo_flush), 32'd0);
    check("rst_read_rst", 32'(o_fifo_read_rst), 32'd0);
    check("rst_mark", 32'(o_fifo_mark_read_rst), 32'd0);
  endtask

  initial begin
    int c;
    n_tests = 0; n_fail = 0; force_left = 0; ff_arm = 1'b0; force_full = 1'b0;
    sv_mode = 1; mr_mode = 1; m_ready = 1'b0; start_req = 1'b0;
    start_items = 0; start_passes = 0; j_items = 1; j_passes = 1;
`ifdef SAMPLE_FIFO_CTRL_ABORT_EN
    abort_req = 1'b0;
`endif
    rst_req = 1'b1;
    repeat (3) tick();
    reset_outs();
    rst_req = 1'b0;
    tick();

    // Four items replayed three times with full throughput
    new_job(4, 3);
    wait_done(500);
    end_checks();

    // Back-pressure from a full FIFO during the third push
    ff_arm = 1'b1;
    new_job(5, 1);
    wait_done(500);
    end_checks();

    // Downstream stalls every other cycle
    mr_mode = 2;
    new_job(8, 1);
    wait_done(500);
    end_checks();
    mr_mode = 1;

    // Degenerate jobs finish immediately with no FIFO activity
    new_job(0, 3);
    tick();
    check("zero_items_done", 32'(o_done), 32'd1);
    check("zero_items_strobes", 32'(n_strb), 32'd0);
    tick();
    check("zero_items_idle", 32'(o_busy), 32'd0);
    new_job(3, 0);
    tick();
    check("zero_passes_done", 32'(o_done), 32'd1);
    check("zero_passes_strobes", 32'(n_strb), 32'd0);
    tick();

    // Reset in the middle of pass 1, then a fresh job
    new_job(6, 3);
    c = 0;
    while (!(m_valid && m_pass == PW'(1)) && c < 500) begin
      tick();
      c++;
    end
    check("reach_pass1", 32'(m_pass), 32'd1);
    rst_req = 1'b1;
    tick();
    rst_req = 1'b0;
    tick();
    reset_outs();
    new_job(5, 2);
    wait_done(500);
    end_checks();

    // Random jobs with random upstream and downstream handshakes
    sv_mode = 0;
    mr_mode = 0;
    for (int r = 0; r < 6; r++) begin
      new_job(int'($urandom_range(1, 15)), int'($urandom_range(1, 4)));
      wait_done(3000);
      end_checks();
    end

`ifdef SAMPLE_FIFO_CTRL_ABORT_EN
    // Abort while the second beat of pass 0 is presented
    sv_mode = 1;
    mr_mode = 1;
    new_job(6, 2);
    c = 0;
    while (!(m_valid && n_beat == 1) && c < 500) begin
      tick();
      c++;
    end
    check("abort_reach_beat2", 32'(n_beat), 32'd1);
    abort_req = 1'b1;
    tick();
    abort_req = 1'b0;
    tick();
    check("abort_m_valid", 32'(m_valid), 32'd0);
    check("abort_flush_now", 32'(o_fifo_flush), 32'd1);
    wait_done(50);
    check("abort_flushes", 32'(n_flush), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
